video_scanout: RTL

//  Reader end of the 160x240 framebuffer that the TIA fills with 7-bit colour indices.

---
 rtl/video_pkg.sv | 41 ++++
 rtl/ntsc_palette.sv | 24 ++
 rtl/video_scanout.sv | 100 ++++++++++
 3 files changed

// File: rtl/video_pkg.sv
// video_pkg: shared VGA timing, source geometry, RGB type and the NTSC index-to-RGB mapping
package video_pkg;

    localparam int SRC_W    = 160;
    localparam int SRC_H    = 240;
    localparam int H_ACTIVE = 640;
    localparam int H_FP     = 16;
    localparam int H_SYNC   = 96;
    localparam int H_BP     = 48;
    localparam int V_ACTIVE = 480;
    localparam int V_FP     = 10;
    localparam int V_SYNC   = 2;
    localparam int V_BP     = 33;

    localparam logic [9:0] H_TOTAL      = 10'(H_ACTIVE + H_FP + H_SYNC + H_BP);
    localparam logic [9:0] V_TOTAL      = 10'(V_ACTIVE + V_FP + V_SYNC + V_BP);
    localparam logic [9:0] H_SYNC_START = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] H_SYNC_END   = 10'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [9:0] V_SYNC_START = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] V_SYNC_END   = 10'(V_ACTIVE + V_FP + V_SYNC);

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb_t;

    // Index = {hue[3:0], lum[2:0]}: hue bits 0..2 tint r/g/b, hue bit 3 warms all channels
    function automatic logic [7:0] ntsc_chan(input logic [2:0] lum, input logic hue, input logic warm);
        logic [8:0] w_sum;
        w_sum = {1'b0, lum, 5'b10000} + (hue ? 9'd32 : 9'd0) + (warm ? 9'd16 : 9'd0);
        return w_sum[8] ? 8'hFF : w_sum[7:0];
    endfunction

    function automatic rgb_t ntsc_rgb(input logic [6:0] idx);
        return {ntsc_chan(idx[2:0], idx[3], idx[6]),
                ntsc_chan(idx[2:0], idx[4], idx[6]),
                ntsc_chan(idx[2:0], idx[5], idx[6])};
    endfunction

endpackage

// File: rtl/ntsc_palette.sv
// ntsc_palette: 128-entry colour ROM with registered, blank-gated read (final pipeline stage)
module ntsc_palette
    import video_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        en_i,
    input  logic        act_i,
    input  logic [6:0]  idx_i,
    output logic [23:0] rgb_o
);

    rgb_t r_rgb;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)
            r_rgb <= '0;
        else if (en_i)
            r_rgb <= act_i ? ntsc_rgb(idx_i) : '0;
    end

    assign rgb_o = r_rgb;

endmodule

// File: rtl/video_scanout.sv
// video_scanout: 640x480 timing, 4x/2x scaled framebuffer fetch and palette output pipeline
module video_scanout
    import video_pkg::*;
#(
    parameter int DATA_WIDTH   = 7,
    parameter int ADDR_WIDTH   = 16,
    parameter int V_ACT_LINES  = V_ACTIVE,
    parameter int V_FP_LINES   = V_FP,
    parameter int V_SYNC_LINES = V_SYNC,
    parameter int V_BP_LINES   = V_BP
)(
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  pix_en_i,
    output logic [ADDR_WIDTH-1:0] fb_addr_o,
    output logic                  fb_rd_o,
    input  logic [DATA_WIDTH-1:0] fb_dat_i,
    output logic [7:0]            red_o,
    output logic [7:0]            green_o,
    output logic [7:0]            blue_o,
    output logic                  hsync_o,
    output logic                  vsync_o,
    output logic                  de_o,
    output logic                  frame_start_o
);

    localparam logic [9:0] H_LAST   = H_TOTAL - 10'd1;
    localparam logic [9:0] H_ACT    = 10'(H_ACTIVE);
    localparam logic [9:0] V_ACT    = 10'(V_ACT_LINES);
    localparam logic [9:0] V_LAST   = 10'(V_ACT_LINES + V_FP_LINES + V_SYNC_LINES + V_BP_LINES - 1);
    localparam logic [9:0] V_VS_BEG = 10'(V_ACT_LINES + V_FP_LINES);
    localparam logic [9:0] V_VS_END = 10'(V_ACT_LINES + V_FP_LINES + V_SYNC_LINES);

    logic [9:0]            r_hcnt, r_vcnt;
    logic                  r_hs0, r_vs0, r_fs0;
    logic                  r_act1, r_hs1, r_vs1, r_fs1, r_fs2;
    logic                  w_hwrap, w_act, w_hs, w_vs;
    logic [ADDR_WIDTH-1:0] w_y, w_x;
    logic [23:0]           w_rgb;

    assign w_hwrap = r_hcnt == H_LAST;
    assign w_act   = (r_hcnt < H_ACT) && (r_vcnt < V_ACT);
    assign w_hs    = (r_hcnt >= H_SYNC_START) && (r_hcnt < H_SYNC_END);
    assign w_vs    = (r_vcnt >= V_VS_BEG) && (r_vcnt < V_VS_END);
    // Dropping low counter bits replicates each source pixel 4x and each source line 2x
    assign w_y     = ADDR_WIDTH'(r_vcnt[9:1]);
    assign w_x     = ADDR_WIDTH'(r_hcnt[9:2]);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_hcnt    <= '0;
            r_vcnt    <= '0;
            fb_addr_o <= '0;
            fb_rd_o   <= 1'b0;
            r_hs0     <= 1'b1;
            r_vs0     <= 1'b1;
            r_fs0     <= 1'b0;
            r_act1    <= 1'b0;
            r_hs1     <= 1'b1;
            r_vs1     <= 1'b1;
            r_fs1     <= 1'b0;
            de_o      <= 1'b0;
            hsync_o   <= 1'b1;
            vsync_o   <= 1'b1;
            r_fs2     <= 1'b0;
        end else if (pix_en_i) begin
            r_hcnt  <= w_hwrap ? '0 : r_hcnt + 10'd1;
            if (w_hwrap)
                r_vcnt <= (r_vcnt == V_LAST) ? '0 : r_vcnt + 10'd1;
            fb_rd_o <= w_act;
            if (w_act)
                fb_addr_o <= (w_y << 7) + (w_y << 5) + w_x;
            r_hs0   <= !w_hs;
            r_vs0   <= !w_vs;
            r_fs0   <= (r_hcnt == 10'd0) && (r_vcnt == 10'd0);
            r_act1  <= fb_rd_o;
            r_hs1   <= r_hs0;
            r_vs1   <= r_vs0;
            r_fs1   <= r_fs0;
            de_o    <= r_act1;
            hsync_o <= r_hs1;
            vsync_o <= r_vs1;
            r_fs2   <= r_fs1;
        end
    end

    // fb_dat_i arrives one pix_en after the address, so it lines up with r_act1 here
    ntsc_palette u_palette (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .en_i   (pix_en_i),
        .act_i  (r_act1),
        .idx_i  (fb_dat_i[6:0]),
        .rgb_o  (w_rgb)
    );

    assign {red_o, green_o, blue_o} = w_rgb;
    assign frame_start_o = r_fs2 && pix_en_i;

endmodule
